// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: request/result bundle between the execute stage and the multiply/divide unit.
interface mips_muldiv_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  modport master (output stall, start, op, a, b, input busy, done, hi, lo);
  modport slave (input stall, start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MIPS multiply/divide unit with HI/LO registers.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise they are ignored like reserved ops.
module mips_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic          clk,
  input logic          rst,
  mips_muldiv_if.slave bus
);
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, bm_q, bm_d, hi_q, hi_d, lo_q, lo_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, dz_q, dz_d, done_q, done_d;
  logic [XLEN-1:0]   r, q, a_mag, b_mag, quo_fix, rem_fix;
  logic [XLEN:0]     t, d;
  logic [2*XLEN-1:0] prod_fix;
  logic              sgn, a_neg, b_neg, is_mul, is_div, is_mt, acc, ge;
  assign is_mul = bus.op == 3'd0 || bus.op == 3'd1;
  assign is_div = DIV_EN && (bus.op == 3'd2 || bus.op == 3'd3);
  assign is_mt  = bus.op == 3'd4 || bus.op == 3'd5;
  assign acc    = bus.start && !bus.stall && (is_mul || is_div || is_mt);
  assign sgn    = !bus.op[0];
  assign a_neg  = sgn && bus.a[XLEN-1];
  assign b_neg  = sgn && bus.b[XLEN-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;
  // One iteration: restoring-divide step on {rem,quo}, or shift-add multiply step
  always_comb begin
    r  = rem_q;
    q  = quo_q;
    t  = '0;
    d  = '0;
    ge = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (DIV_EN && div_q) begin
        t  = {r, q[XLEN-1]};
        d  = t - {1'b0, bm_q};
        ge = t >= {1'b0, bm_q};
        r  = ge ? d[XLEN-1:0] : t[XLEN-1:0];
        q  = {q[XLEN-2:0], ge};
      end else begin
        t = {1'b0, r} + (q[0] ? {1'b0, bm_q} : '0);
        r = t[XLEN:1];
        q = {t[0], q[XLEN-1:1]};
      end
    end
  end
  assign prod_fix = neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
  assign quo_fix  = dz_q ? '1 : neg_q ? -quo_q : quo_q;
  assign rem_fix  = rneg_q ? -rem_q : rem_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bm_d    = bm_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = done_q;
    if (!bus.stall) begin
      done_d = 1'b0;
      if (state_q == ITER) begin
        rem_d   = r;
        quo_d   = q;
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? FIX : ITER;
      end else if (state_q == FIX) begin
        hi_d    = div_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
        lo_d    = div_q ? quo_fix : prod_fix[XLEN-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      // A new request wins over any commit in the same cycle
      if (acc) begin
        hi_d    = bus.op == 3'd4 ? bus.a : hi_q;
        lo_d    = bus.op == 3'd5 ? bus.a : lo_q;
        done_d  = 1'b0;
        state_d = is_mt ? IDLE : ITER;
        cnt_d   = CW'(N);
        rem_d   = '0;
        quo_d   = is_div ? a_mag : b_mag;
        bm_d    = is_div ? b_mag : a_mag;
        neg_d   = a_neg ^ b_neg;
        rneg_d  = is_div && a_neg;
        div_d   = is_div;
        dz_d    = is_div && bus.b == '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bm_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bm_q    <= bm_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q && !bus.stall;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed checks of multiply, divide, stall, abort and reset behaviour.
module tb_mips_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int pass_n = 0;
  int total_n = 0;
  mips_muldiv_if #(.XLEN(32)) bus();
  mips_muldiv #(.XLEN(32), .UNROLL(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total_n += 4;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_n++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_n++;
    if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", bus.hi); else pass_n++;
    if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", bus.lo); else pass_n++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    int cyc;
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    run(cyc);
    total_n += 5;
    if (cyc != 33) $display("FAIL mult_latency: got %0d want 33", cyc); else pass_n++;
    if (bus.done !== 1'b1) $display("FAIL mult_done: got %b want 1", bus.done); else pass_n++;
    if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", bus.hi); else pass_n++;
    if (bus.lo !== 32'hFFFF_FFFE) $display("FAIL mult_lo: got %h want fffffffe", bus.lo); else pass_n++;
    @(negedge clk);
    if (bus.done !== 1'b0) $display("FAIL mult_done_pulse: got %b want 0", bus.done); else pass_n++;
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    run(cyc);
    total_n += 2;
    if (bus.hi !== 32'h1) $display("FAIL multu_hi: got %h want 00000001", bus.hi); else pass_n++;
    if (bus.lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h want fffffffe", bus.lo); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_div;
`ifdef MULDIV_DIV_EN
    logic [2:0]  ops [4] = '{3'd2, 3'd3, 3'd3, 3'd2};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ehi [4] = '{32'hFFFF_FFFF, 32'd2, 32'd5, 32'h0};
    logic [31:0] elo [4] = '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      run(cyc);
      total_n += 3;
      if (cyc != 33) $display("FAIL div%0d_latency: got %0d want 33", i, cyc); else pass_n++;
      if (bus.hi !== ehi[i]) $display("FAIL div%0d_hi: got %h want %h", i, bus.hi, ehi[i]); else pass_n++;
      if (bus.lo !== elo[i]) $display("FAIL div%0d_lo: got %h want %h", i, bus.lo, elo[i]); else pass_n++;
      @(negedge clk);
    end
`else
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    total_n += 3;
    if (bus.busy !== 1'b0) $display("FAIL div_off_busy: got %b want 0", bus.busy); else pass_n++;
    if (bus.hi !== 32'h1) $display("FAIL div_off_hi: got %h want 00000001", bus.hi); else pass_n++;
    if (bus.lo !== 32'hFFFF_FFFE) $display("FAIL div_off_lo: got %h want fffffffe", bus.lo); else pass_n++;
    issue(3'd7, 32'd9, 32'd9);
    total_n += 1;
    if (bus.busy !== 1'b0) $display("FAIL reserved_busy: got %b want 0", bus.busy); else pass_n++;
`endif
  endtask

  task automatic test_mt;
    issue(3'd4, 32'h55, 32'h0);
    total_n += 2;
    if (bus.hi !== 32'h55) $display("FAIL mthi_hi: got %h want 00000055", bus.hi); else pass_n++;
    if (bus.busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", bus.busy); else pass_n++;
    issue(3'd5, 32'hAA, 32'h0);
    total_n += 3;
    if (bus.lo !== 32'hAA) $display("FAIL mtlo_lo: got %h want 000000aa", bus.lo); else pass_n++;
    if (bus.hi !== 32'h55) $display("FAIL mtlo_hi: got %h want 00000055", bus.hi); else pass_n++;
    if (bus.done !== 1'b0) $display("FAIL mt_done: got %b want 0", bus.done); else pass_n++;
  endtask

  task automatic test_stall;
    int cyc = 0;
    issue(3'd1, 32'd3, 32'd4);
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      bus.stall = cyc >= 10 && cyc < 15;
      @(negedge clk);
    end
    bus.stall = 1'b0;
    total_n += 4;
    if (cyc != 38) $display("FAIL stall_latency: got %0d want 38", cyc); else pass_n++;
    if (bus.done !== 1'b1) $display("FAIL stall_done: got %b want 1", bus.done); else pass_n++;
    if (bus.lo !== 32'd12) $display("FAIL stall_lo: got %h want 0000000c", bus.lo); else pass_n++;
    if (bus.hi !== 32'd0) $display("FAIL stall_hi: got %h want 0", bus.hi); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_abort;
    bit seen = 1'b0;
    issue(3'd5, 32'hAA, 32'h0);
    issue(3'd0, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    issue(3'd4, 32'h1234, 32'h0);
    total_n += 3;
    if (bus.hi !== 32'h1234) $display("FAIL abort_hi: got %h want 00001234", bus.hi); else pass_n++;
    if (bus.lo !== 32'hAA) $display("FAIL abort_lo: got %h want 000000aa", bus.lo); else pass_n++;
    if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else pass_n++;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    total_n += 2;
    if (seen !== 1'b0) $display("FAIL abort_no_done: got %b want 0", seen); else pass_n++;
    if (bus.lo !== 32'hAA) $display("FAIL abort_lo_kept: got %h want 000000aa", bus.lo); else pass_n++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(3'd1, 32'd2, 32'd3);
    run(cyc);
    total_n += 2;
    if (bus.done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", bus.done); else pass_n++;
    if (bus.lo !== 32'd6) $display("FAIL b2b_first_lo: got %h want 00000006", bus.lo); else pass_n++;
    issue(3'd1, 32'd7, 32'd9);
    total_n += 2;
    if (bus.busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", bus.busy); else pass_n++;
    if (bus.done !== 1'b0) $display("FAIL b2b_done_clear: got %b want 0", bus.done); else pass_n++;
    run(cyc);
    total_n += 2;
    if (cyc != 33) $display("FAIL b2b_latency: got %0d want 33", cyc); else pass_n++;
    if (bus.lo !== 32'd63) $display("FAIL b2b_lo: got %h want 0000003f", bus.lo); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc;
    issue(3'd4, 32'hDEAD, 32'h0);
    issue(3'd1, 32'hFFFF, 32'hFFFF);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total_n += 4;
    if (bus.busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", bus.busy); else pass_n++;
    if (bus.done !== 1'b0) $display("FAIL rmid_done: got %b want 0", bus.done); else pass_n++;
    if (bus.hi !== 32'h0) $display("FAIL rmid_hi: got %h want 0", bus.hi); else pass_n++;
    if (bus.lo !== 32'h0) $display("FAIL rmid_lo: got %h want 0", bus.lo); else pass_n++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(3'd1, 32'd6, 32'd7);
    run(cyc);
    total_n += 3;
    if (cyc != 33) $display("FAIL rmid_latency: got %0d want 33", cyc); else pass_n++;
    if (bus.lo !== 32'd42) $display("FAIL rmid_lo42: got %h want 0000002a", bus.lo); else pass_n++;
    if (bus.hi !== 32'd0) $display("FAIL rmid_hi0: got %h want 0", bus.hi); else pass_n++;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_mul();
    test_div();
    test_mt();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
